// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: opcodes, FSM encoding,
// reset vector default and J/B immediate extraction helpers.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_predecode.sv
// Static branch predictor for fetch: JAL always taken, backward branches taken.
// Only compiled when FETCH_STATIC_PREDICT_EN is defined.
`ifdef FETCH_STATIC_PREDICT_EN
module fetch_predecode
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o
);

  logic signed [31:0] imm_j_s;
  logic signed [31:0] imm_b_s;
  logic [31:0]        tgt_j;
  logic [31:0]        tgt_b;
  logic [31:0]        pc_plus4;
  logic               is_jal;
  logic               is_bwd_branch;

  assign imm_j_s       = imm_j(inst_i);
  assign imm_b_s       = imm_b(inst_i);
  assign tgt_j         = pc_i + $unsigned(imm_j_s);
  assign tgt_b         = pc_i + $unsigned(imm_b_s);
  assign pc_plus4      = pc_i + 32'd4;
  assign is_jal        = (inst_i[6:0] == OP_JAL);
  assign is_bwd_branch = (inst_i[6:0] == OP_BRANCH) && (imm_b_s < 0);

  // A misaligned target would fault in fetch; leave it for EX to resolve.
  always_comb begin
    pred_taken_o = 1'b0;
    pred_pc_o    = pc_plus4;
    if (is_jal && (tgt_j[1:0] == 2'b00)) begin
      pred_taken_o = 1'b1;
      pred_pc_o    = tgt_j;
    end else if (is_bwd_branch && (tgt_b[1:0] == 2'b00)) begin
      pred_taken_o = 1'b1;
      pred_pc_o    = tgt_b;
    end
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// RV32I fetch: PC register, boot/run/fault FSM and IF/ID pipeline register.
// Optional static prediction enabled by FETCH_STATIC_PREDICT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_inst,
  input  logic [4:0]      imem_rd,
  input  logic [4:0]      imem_rs1,
  input  logic [4:0]      imem_rs2,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_inst,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic            id_pred_taken,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic [4:0]      id_rd_q, id_rd_d;
  logic [4:0]      id_rs1_q, id_rs1_d;
  logic [4:0]      id_rs2_q, id_rs2_d;
  logic            id_pred_q, id_pred_d;

  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_STATIC_PREDICT_EN
  fetch_predecode u_predecode (
    .pc_i         (pc_q),
    .inst_i       (imem_inst),
    .pred_taken_o (pred_taken),
    .pred_pc_o    (pred_pc)
  );
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = pc_plus4;
`endif

  // Trap has absolute priority and is the only way out of S_FAULT.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_pc_d    = fault_pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_inst_d     = id_inst_q;
    id_rd_d       = id_rd_q;
    id_rs1_d      = id_rs1_q;
    id_rs2_d      = id_rs2_q;
    id_pred_d     = id_pred_q;

    if (trap_valid) begin
      state_d    = S_RUN;
      pc_d       = trap_pc;
      fault_pc_d = '0;
      id_valid_d = 1'b0;
      id_pred_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_d    = S_RUN;
          id_valid_d = 1'b0;
        end
        S_RUN: begin
          if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            id_pred_d  = 1'b0;
          end else if (redirect_valid) begin
            state_d    = S_FAULT;
            fault_pc_d = redirect_pc;
            id_valid_d = 1'b0;
            id_pred_d  = 1'b0;
          end else if (stall) begin
            if (flush) id_valid_d = 1'b0;
          end else begin
            pc_d          = pred_taken ? pred_pc : pc_plus4;
            id_valid_d    = ~flush;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_inst_d     = imem_inst;
            id_rd_d       = imem_rd;
            id_rs1_d      = imem_rs1;
            id_rs2_d      = imem_rs2;
            id_pred_d     = pred_taken;
          end
        end
        S_FAULT: begin
          id_valid_d = 1'b0;
        end
        default: begin
          state_d    = S_FAULT;
          id_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      fault_pc_q    <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_inst_q     <= '0;
      id_rd_q       <= '0;
      id_rs1_q      <= '0;
      id_rs2_q      <= '0;
      id_pred_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_pc_q    <= fault_pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_inst_q     <= id_inst_d;
      id_rd_q       <= id_rd_d;
      id_rs1_q      <= id_rs1_d;
      id_rs2_q      <= id_rs2_d;
      id_pred_q     <= id_pred_d;
    end
  end

  assign imem_pc       = pc_q;
  assign id_valid      = id_valid_q;
  assign id_pc         = id_pc_q;
  assign id_pc_plus4   = id_pc_plus4_q;
  assign id_inst       = id_inst_q;
  assign id_rd         = id_rd_q;
  assign id_rs1        = id_rs1_q;
  assign id_rs2        = id_rs2_q;
  assign id_pred_taken = id_pred_q;
  assign fetch_fault   = (state_q == S_FAULT);
  assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a small combinational imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic [4:0]  imem_rd, imem_rs1, imem_rs2;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_inst;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        id_pred_taken;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [64];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_pc[7:2]];
  assign imem_rd   = imem_inst[11:7];
  assign imem_rs1  = imem_inst[19:15];
  assign imem_rs2  = imem_inst[24:20];

  fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .imem_rd        (imem_rd),
    .imem_rs1       (imem_rs1),
    .imem_rs2       (imem_rs2),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_inst        (id_inst),
    .id_rd          (id_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_pred_taken  (id_pred_taken),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i % 32) << 7);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0060_0113;

    #2;
    check_vec("rst_imem_pc", imem_pc, 32'h0);
    check_vec("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check_vec("rst_id_pc", id_pc, 32'h0);
    check_vec("rst_id_inst", id_inst, 32'h0);
    check_vec("rst_fault", {31'b0, fetch_fault}, 32'h0);
    check_vec("rst_fault_pc", fault_pc, 32'h0);
    check_vec("rst_pred", {31'b0, id_pred_taken}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    step();
    check_vec("boot_imem_pc", imem_pc, 32'h0);
    check_vec("boot_id_valid", {31'b0, id_valid}, 32'h0);
    step();
    check_vec("run1_imem_pc", imem_pc, 32'h4);
    check_vec("run1_id_valid", {31'b0, id_valid}, 32'h1);
    check_vec("run1_id_pc", id_pc, 32'h0);
    check_vec("run1_id_inst", id_inst, 32'h0050_0093);
    check_vec("run1_id_rd", {27'b0, id_rd}, 32'd1);
    check_vec("run1_id_pc4", id_pc_plus4, 32'h4);
    step();
    check_vec("run2_imem_pc", imem_pc, 32'h8);
    check_vec("run2_id_inst", id_inst, 32'h0060_0113);
    check_vec("run2_id_rd", {27'b0, id_rd}, 32'd2);
    step();
    step();
    check_vec("run4_imem_pc", imem_pc, 32'h10);
    check_vec("run4_id_pc", id_pc, 32'hC);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec("stall_imem_pc", imem_pc, 32'h10);
      check_vec("stall_id_pc", id_pc, 32'hC);
      check_vec("stall_id_valid", {31'b0, id_valid}, 32'h1);
    end
    flush = 1'b1;
    step();
    check_vec("stflush_id_valid", {31'b0, id_valid}, 32'h0);
    check_vec("stflush_imem_pc", imem_pc, 32'h10);
    check_vec("stflush_id_pc", id_pc, 32'hC);
    flush = 1'b0;

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    check_vec("redir_imem_pc", imem_pc, 32'h40);
    check_vec("redir_id_valid", {31'b0, id_valid}, 32'h0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step();
    check_vec("redir2_imem_pc", imem_pc, 32'h44);
    check_vec("redir2_id_valid", {31'b0, id_valid}, 32'h1);
    check_vec("redir2_id_pc", id_pc, 32'h40);
    check_vec("redir2_id_rd", {27'b0, id_rd}, 32'd16);

    flush = 1'b1;
    step();
    check_vec("flush_id_valid", {31'b0, id_valid}, 32'h0);
    check_vec("flush_imem_pc", imem_pc, 32'h48);
    flush = 1'b0;

    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    check_vec("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check_vec("mis_fault_pc", fault_pc, 32'h42);
    check_vec("mis_imem_pc", imem_pc, 32'h48);
    check_vec("mis_id_valid", {31'b0, id_valid}, 32'h0);
    redirect_pc = 32'h80;
    step();
    check_vec("fault_ign_redir_pc", imem_pc, 32'h48);
    check_vec("fault_hold", {31'b0, fetch_fault}, 32'h1);
    redirect_valid = 1'b0;
    trap_valid     = 1'b1;
    trap_pc        = 32'h100;
    step();
    check_vec("trap_fault_clr", {31'b0, fetch_fault}, 32'h0);
    check_vec("trap_imem_pc", imem_pc, 32'h100);
    check_vec("trap_id_valid", {31'b0, id_valid}, 32'h0);
    trap_valid = 1'b0;
    step();
    check_vec("trap2_id_pc", id_pc, 32'h100);
    check_vec("trap2_imem_pc", imem_pc, 32'h104);

    trap_valid = 1'b1;
    trap_pc    = 32'hFFFF_FFFC;
    step();
    trap_valid = 1'b0;
    check_vec("wrap_pre_pc", imem_pc, 32'hFFFF_FFFC);
    step();
    check_vec("wrap_imem_pc", imem_pc, 32'h0);
    check_vec("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check_vec("wrap_id_pc4", id_pc_plus4, 32'h0);
    check_vec("wrap_id_rd", {27'b0, id_rd}, 32'd31);

    trap_valid     = 1'b1;
    trap_pc        = 32'h200;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    check_vec("trap_vs_redir", imem_pc, 32'h200);
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;

`ifdef FETCH_STATIC_PREDICT_EN
    mem[8]     = 32'hFE00_0CE3;
    trap_valid = 1'b1;
    trap_pc    = 32'h20;
    step();
    trap_valid = 1'b0;
    step();
    check_vec("pred_bwd_pc", imem_pc, 32'h18);
    check_vec("pred_bwd_taken", {31'b0, id_pred_taken}, 32'h1);
    mem[8]     = 32'h0000_0463;
    trap_valid = 1'b1;
    step();
    trap_valid = 1'b0;
    step();
    check_vec("pred_fwd_pc", imem_pc, 32'h24);
    check_vec("pred_fwd_taken", {31'b0, id_pred_taken}, 32'h0);
`endif

    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_vec("arst_imem_pc", imem_pc, 32'h0);
    check_vec("arst_id_valid", {31'b0, id_valid}, 32'h0);
    check_vec("arst_id_pc", id_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_vec("arst_boot_pc", imem_pc, 32'h0);
    step();
    check_vec("arst_run_pc", imem_pc, 32'h4);
    check_vec("arst_run_id_pc", id_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
